// File: rtl/stage_id_queue_if.sv
// Fetch-to-decode payload type and the handshake interface of stage_id_queue.
// The package precedes the interface because the interface carries if2id_t.
package stage_id_queue_pkg;
  typedef struct packed {
    logic        if_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        if_inst_valid;
    logic        if_misaligned;
    logic        if_acc_fault;
  } if2id_t;
endpackage

interface stage_id_queue_if #(
  parameter int DEPTH = 4,
  parameter int IRQW  = 4
);
  import stage_id_queue_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Input side: an entry transfers on a clock edge where in_valid && in_ready && !id_flush.
  // Output side: the head retires on an edge where out_valid && id_ready && !reg_read_busy && !id_flush.
  logic            in_valid;
  if2id_t          in_data;
  logic            in_ready;
  logic            irq;
  logic [IRQW-1:0] irq_type;
  logic            id_flush;
  logic            id_ready;
  logic            reg_read_busy;
  logic            out_valid;
  if2id_t          out_data;
  logic            out_irq;
  logic [IRQW-1:0] out_irq_type;
  logic            id_stall;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  modport slave (
    input  in_valid, in_data, irq, irq_type, id_flush, id_ready, reg_read_busy,
    output in_ready, out_valid, out_data, out_irq, out_irq_type, id_stall, count,
    output rd_ptr, wr_ptr
  );

  modport master (
    output in_valid, in_data, irq, irq_type, id_flush, id_ready, reg_read_busy,
    input  in_ready, out_valid, out_data, out_irq, out_irq_type, id_stall, count,
    input  rd_ptr, wr_ptr
  );
endinterface

// File: rtl/stage_id_queue.sv
// Fetch-to-decode circular queue with per-entry interrupt tag and flush.
// Define ID_QUEUE_BYPASS_EN to let an entry reach the head of an empty queue in the same cycle.
module stage_id_queue
  import stage_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IRQW  = 4
) (
  input  logic              clock,
  input  logic              reset,
  stage_id_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if2id_t          mem_data_q     [DEPTH];
  logic            mem_irq_q      [DEPTH];
  logic [IRQW-1:0] mem_irq_type_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic   in_ready;
  logic   out_valid;
  logic   bypass;
  logic   enq;
  logic   deq;
  logic   mem_wr;
  logic   mem_rd;
  if2id_t wr_entry;

`ifdef ID_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && bus.in_valid && !bus.id_flush;
`else
  assign bypass = 1'b0;
`endif

  // in_ready looks only at occupancy, so a full queue never takes an entry
  // even when the head retires in the same cycle.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0) || bypass;
  assign enq       = bus.in_valid && in_ready && !bus.id_flush;
  assign deq       = out_valid && bus.id_ready && !bus.reg_read_busy && !bus.id_flush;
  assign mem_wr    = enq && !(bypass && deq);
  assign mem_rd    = deq && !bypass;

  always_comb begin
    wr_entry          = bus.in_data;
    wr_entry.if_valid = 1'b1;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.id_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (mem_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (mem_rd) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(mem_wr) - CW'(mem_rd);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; the head mux below masks stale contents.
  always_ff @(posedge clock) begin
    if (!reset && mem_wr) begin
      mem_data_q[wr_ptr_q]     <= wr_entry;
      mem_irq_q[wr_ptr_q]      <= bus.irq;
      mem_irq_type_q[wr_ptr_q] <= bus.irq_type;
    end
  end

  always_comb begin
    bus.out_data     = '0;
    bus.out_irq      = 1'b0;
    bus.out_irq_type = '0;
    if (bypass) begin
      bus.out_data     = wr_entry;
      bus.out_irq      = bus.irq;
      bus.out_irq_type = bus.irq_type;
    end else if (count_q != '0) begin
      bus.out_data     = mem_data_q[rd_ptr_q];
      bus.out_irq      = mem_irq_q[rd_ptr_q];
      bus.out_irq_type = mem_irq_type_q[rd_ptr_q];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.id_stall  = out_valid && bus.reg_read_busy;
  assign bus.count     = count_q;
  assign bus.rd_ptr    = rd_ptr_q;
  assign bus.wr_ptr    = wr_ptr_q;
endmodule

// File: tb/tb_stage_id_queue.sv
// Directed and randomized bench for stage_id_queue against a queue-based reference model.
// Define ID_QUEUE_BYPASS_EN for both bench and RTL to exercise the bypass build.
module tb_stage_id_queue;
  import stage_id_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int IRQW  = 4;
  localparam int EW    = 67 + 1 + IRQW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stage_id_queue_if #(.DEPTH(DEPTH), .IRQW(IRQW)) bus();
  stage_id_queue #(.DEPTH(DEPTH), .IRQW(IRQW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [EW-1:0] exp_q[$];
  int wr_n;
  int rd_n;
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack_in();
    return {bus.in_data.pc, bus.in_data.instr, bus.in_data.if_inst_valid,
            bus.in_data.if_misaligned, bus.in_data.if_acc_fault, bus.irq, bus.irq_type};
  endfunction

  function automatic logic [EW-1:0] pack_out();
    return {bus.out_data.pc, bus.out_data.instr, bus.out_data.if_inst_valid,
            bus.out_data.if_misaligned, bus.out_data.if_acc_fault, bus.out_irq, bus.out_irq_type};
  endfunction

  function automatic bit model_bypass();
`ifdef ID_QUEUE_BYPASS_EN
    return (exp_q.size() == 0) && bus.in_valid && !bus.id_flush;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic irq,
                       input logic [IRQW-1:0] it, input logic fl, input logic idr,
                       input logic busy);
    bus.in_valid               = v;
    bus.in_data.if_valid       = v;
    bus.in_data.pc             = pc;
    bus.in_data.instr          = $urandom;
    bus.in_data.if_inst_valid  = 1'($urandom_range(0, 1));
    bus.in_data.if_misaligned  = 1'($urandom_range(0, 1));
    bus.in_data.if_acc_fault   = 1'($urandom_range(0, 1));
    bus.irq                    = irq;
    bus.irq_type               = it;
    bus.id_flush               = fl;
    bus.id_ready               = idr;
    bus.reg_read_busy          = busy;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare every output against the model; inputs must already be applied.
  task automatic check_outputs(input string tag);
    bit            bp;
    bit            ov;
    logic [EW-1:0] head;
    #1;
    bp   = model_bypass();
    ov   = (exp_q.size() != 0) || bp;
    head = bp ? pack_in() : ((exp_q.size() != 0) ? exp_q[0] : '0);
    check({tag, "_count"},    bus.count,             exp_q.size());
    check({tag, "_in_ready"}, bus.in_ready,          exp_q.size() != DEPTH);
    check({tag, "_out_valid"}, bus.out_valid,        ov);
    check({tag, "_if_valid"}, bus.out_data.if_valid, ov);
    check({tag, "_head"},     pack_out(),            head);
    check({tag, "_id_stall"}, bus.id_stall,          ov && bus.reg_read_busy);
    check({tag, "_rd_ptr"},   bus.rd_ptr,            rd_n % DEPTH);
    check({tag, "_wr_ptr"},   bus.wr_ptr,            wr_n % DEPTH);
  endtask

  // Advance the model by the rules for the currently applied inputs, then clock.
  task automatic tick();
    bit bp;
    bit ov;
    bit enq;
    bit deq;
    if (reset || bus.id_flush) begin
      exp_q.delete();
      wr_n = 0;
      rd_n = 0;
    end else begin
      bp  = model_bypass();
      ov  = (exp_q.size() != 0) || bp;
      enq = bus.in_valid && (exp_q.size() != DEPTH);
      deq = ov && bus.id_ready && !bus.reg_read_busy;
      if (bp) begin
        if (!deq) begin
          exp_q.push_back(pack_in());
          wr_n++;
        end
      end else begin
        if (deq) begin
          void'(exp_q.pop_front());
          rd_n++;
        end
        if (enq) begin
          exp_q.push_back(pack_in());
          wr_n++;
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cyc(input string tag, input logic v, input logic [31:0] pc, input logic irq,
                     input logic [IRQW-1:0] it, input logic fl, input logic idr,
                     input logic busy);
    drive(v, pc, irq, it, fl, idr, busy);
    if (!reset) check_outputs(tag);
    tick();
  endtask

  initial begin
    wr_n  = 0;
    rd_n  = 0;
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    idle();
    check_outputs("rst");
    check("rst_count", bus.count, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_irq", {bus.out_irq, bus.out_irq_type}, 0);
    tick();

    for (int i = 0; i < 4; i++)
      cyc("fill", 1'b1, 32'h1000 + 32'(4 * i), 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h1010, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_outputs("full");
    check("full_count", bus.count, 4);
    check("full_in_ready", bus.in_ready, 0);
    check("full_head_pc", bus.out_data.pc, 32'h1000);
    tick();
    idle();
    check_outputs("drop");
    check("drop_count", bus.count, 3);
    check("drop_head_pc", bus.out_data.pc, 32'h1004);
    tick();

    cyc("deq", 1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
      check_outputs("busy");
      check("busy_stall", bus.id_stall, 1);
      check("busy_count", bus.count, 2);
      check("busy_head_pc", bus.out_data.pc, 32'h1008);
      tick();
    end
    cyc("release", 1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle();
    check_outputs("released");
    check("released_count", bus.count, 1);
    check("released_head_pc", bus.out_data.pc, 32'h100C);
    tick();

    cyc("pre_flush", 1'b1, 32'h1100, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc("pre_flush", 1'b1, 32'h1104, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc("flush", 1'b1, 32'h1108, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle();
    check_outputs("flushed");
    check("flushed_count", bus.count, 0);
    check("flushed_out_valid", bus.out_valid, 0);
    check("flushed_ptrs", {bus.rd_ptr, bus.wr_ptr}, 0);
    tick();
    for (int i = 0; i < 10; i++)
      cyc("wrap", 1'b1, 32'h1200 + 32'(4 * i), 1'b0, '0, 1'b0,
          (i > 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++)
      cyc("drain", 1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    cyc("irq", 1'b1, 32'h1300, 1'b0, '0,       1'b0, 1'b0, 1'b0);
    cyc("irq", 1'b1, 32'h1304, 1'b1, IRQW'(7), 1'b0, 1'b0, 1'b0);
    cyc("irq", 1'b1, 32'h1308, 1'b0, '0,       1'b0, 1'b0, 1'b0);
    cyc("irq_nov", 1'b0, 32'h0, 1'b1, IRQW'(5), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      check_outputs("irq_head");
      check("irq_tag", {bus.out_irq, bus.out_irq_type}, (k == 1) ? {1'b1, IRQW'(7)} : '0);
      check("irq_valid", bus.out_valid, k < 3);
      tick();
    end

    drive(1'b1, 32'h2000, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_outputs("lat");
`ifdef ID_QUEUE_BYPASS_EN
    check("byp_out_valid", bus.out_valid, 1);
    check("byp_pc", bus.out_data.pc, 32'h2000);
    check("byp_count", bus.count, 0);
    tick();
    idle();
    check_outputs("byp_after");
    check("byp_after_count", bus.count, 0);
    tick();
`else
    check("lat_out_valid", bus.out_valid, 0);
    tick();
    idle();
    check_outputs("lat_next");
    check("lat_next_valid", bus.out_valid, 1);
    check("lat_next_pc", bus.out_data.pc, 32'h2000);
    tick();
`endif

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      cyc("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          IRQW'($urandom_range(0, (1 << IRQW) - 1)), ($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    reset = 1'b0;
    idle();
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
